step_ctrl: RTL and testbench

Front-panel run/step controller that drives the HALT and EN_L inputs of the processor's halt unit. It debounces the RUN and STEP push-buttons and supports burst stepping (N instructions) and a single PC breakpoint. EN_L is issued as an active-low, one-cycle-low pulse. The halt unit reads each high-to-low transition of EN_L as permission for exactly one clock of execution while HALT is high.

---
 rtl/step_ctrl.sv | 170 +++++++++++++++++
 tb/tb_step_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// step_ctrl: front-panel run/step controller for the processor halt unit.
// Debounces the RUN and STEP buttons, runs bursts of N single steps with a
// fixed EN_L-high gap between pulses, and stops RUNNING on a PC breakpoint.
//
// Interface contract: BURST_GO is a one-cycle strobe with no back-pressure.
// It is honoured only when the controller is HALTED (and BURST_N != 0) and
// is silently dropped otherwise; BUSY reports an accepted burst in flight.
module step_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int GAP_CYCLES = 2,
  parameter int ADDR_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUN_BTN,
  input  logic              STEP_BTN,
  input  logic              BURST_GO,
  input  logic [7:0]        BURST_N,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] BP_ADDR,
  input  logic              BP_EN,
  output logic              HALT,
  output logic              EN_L,
  output logic              BUSY,
  output logic              BP_HIT,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] S_HALTED  = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_PULSE   = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Bit 0 is the RUN button, bit 1 the STEP button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    lvl_q;
  logic [1:0]    ev_q;
  logic [DW-1:0] deb_cnt_q [2];

  logic          run_ev;
  logic          step_ev;

  logic [1:0]    state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          busy_q, busy_d;
  logic          bp_hit_q, bp_hit_d;
  logic          halt_q;
  logic          en_l_q;

  assign btn_raw = {STEP_BTN, RUN_BTN};
  assign run_ev  = ev_q[0];
  assign step_ev = ev_q[1];

  // Synchronize both buttons, accept a new level after DEB_CYCLES stable
  // differing samples, and emit a registered one-cycle event on accepted presses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      lvl_q        <= '0;
      ev_q         <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int b = 0; b < 2; b++) begin
        ev_q[b] <= 1'b0;
        if (sync2_q[b] == lvl_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) begin
          deb_cnt_q[b] <= '0;
          lvl_q[b]     <= sync2_q[b];
          ev_q[b]      <= sync2_q[b];
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  // Next-state logic for run/step sequencing; a RUN press always wins.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    bp_hit_d = bp_hit_q;
    case (state_q)
      S_HALTED: begin
        if (run_ev) begin
          state_d  = S_RUNNING;
          bp_hit_d = 1'b0;
        end else if (BURST_GO && (BURST_N != 8'd0)) begin
          state_d = S_PULSE;
          count_d = BURST_N;
          busy_d  = 1'b1;
        end else if (step_ev) begin
          state_d = S_PULSE;
          count_d = 8'd1;
        end
      end
      S_RUNNING: begin
        if (run_ev) begin
          state_d = S_HALTED;
        end else if (BP_EN && (PC == BP_ADDR)) begin
          state_d  = S_HALTED;
          bp_hit_d = 1'b1;
        end
      end
      S_PULSE: begin
        if (run_ev || (count_q == 8'd1)) begin
          state_d = S_HALTED;
          count_d = 8'd0;
          busy_d  = 1'b0;
        end else begin
          state_d = S_GAP;
          count_d = count_q - 8'd1;
          gap_d   = '0;
        end
      end
      default: begin
        if (run_ev) begin
          state_d = S_HALTED;
          count_d = 8'd0;
          busy_d  = 1'b0;
        end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_PULSE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they change on the same edge as the state without any combinational path.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_HALTED;
      count_q  <= 8'd0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      halt_q   <= 1'b1;
      en_l_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      bp_hit_q <= bp_hit_d;
      halt_q   <= (state_d != S_RUNNING);
      en_l_q   <= (state_d != S_PULSE);
    end
  end

  assign HALT        = halt_q;
  assign EN_L        = en_l_q;
  assign BUSY        = busy_q;
  assign BP_HIT      = bp_hit_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed scenarios plus randomized button/burst/PC traffic,
// checked every cycle against a timeline model of the run/step controller.
module tb_step_ctrl;

  localparam int DEB = 4;
  localparam int GAP = 2;
  localparam int AW  = 8;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_btn = 1'b0;
  logic          step_btn = 1'b0;
  logic          burst_go = 1'b0;
  logic [7:0]    burst_n = 8'd0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] bp_addr = '0;
  logic          bp_en = 1'b0;
  logic          halt, en_l, busy, bp_hit;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  step_ctrl #(
    .DEB_CYCLES(DEB),
    .GAP_CYCLES(GAP),
    .ADDR_W    (AW)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .RUN_BTN    (run_btn),
    .STEP_BTN   (step_btn),
    .BURST_GO   (burst_go),
    .BURST_N    (burst_n),
    .PC         (pc),
    .BP_ADDR    (bp_addr),
    .BP_EN      (bp_en),
    .HALT       (halt),
    .EN_L       (en_l),
    .BUSY       (busy),
    .BP_HIT     (bp_hit),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons are kept as a raw sample history; a press is a window of DEB
  // synchronized samples all opposite to the accepted level. Stepping is a
  // timeline: after burst start edge s, offset o=e-s is a pulse when
  // o % (GAP+1) == 0, and the burst covers offsets 0 .. (N-1)*(GAP+1).
  bit   run_hist[$];
  bit   step_hist[$];
  int   cyc;
  bit   m_lvl[2];
  bit   m_rose[2];
  bit   m_running, m_bp_hit, m_bvalid, m_bbusy;
  int   m_bstart, m_bn;
  logic exp_halt, exp_en_l, exp_busy, exp_bp_hit;

  function automatic bit raw_at(int b, int c);
    if (c < 1 || c > run_hist.size()) return 1'b0;
    return (b == 0) ? run_hist[c-1] : step_hist[c-1];
  endfunction

  function automatic int last_off();
    return (m_bn - 1) * (GAP + 1);
  endfunction

  task automatic model_reset();
    cyc = 0;
    run_hist.delete();
    step_hist.delete();
    m_lvl[0] = 0; m_lvl[1] = 0; m_rose[0] = 0; m_rose[1] = 0;
    m_running = 0; m_bp_hit = 0; m_bvalid = 0; m_bbusy = 0;
    m_bstart = 0; m_bn = 1;
    exp_halt = 1; exp_en_l = 1; exp_busy = 0; exp_bp_hit = 0;
  endtask

  task automatic model_edge();
    bit ev[2];
    bit all_diff;
    bit was_step, now_step;
    cyc++;
    run_hist.push_back(run_btn);
    step_hist.push_back(step_btn);
    for (int b = 0; b < 2; b++) begin
      ev[b] = m_rose[b];
      all_diff = 1;
      for (int k = 0; k < DEB; k++)
        if (raw_at(b, cyc - 2 - k) == m_lvl[b]) all_diff = 0;
      if (all_diff) begin
        m_lvl[b]  = !m_lvl[b];
        m_rose[b] = m_lvl[b];
      end else begin
        m_rose[b] = 0;
      end
    end
    was_step = m_bvalid && ((cyc - 1 - m_bstart) <= last_off());
    if (m_running) begin
      if (ev[0]) m_running = 0;
      else if (bp_en && (pc == bp_addr)) begin
        m_running = 0;
        m_bp_hit  = 1;
      end
    end else if (was_step) begin
      if (ev[0]) m_bvalid = 0;
    end else begin
      if (ev[0]) begin
        m_running = 1;
        m_bp_hit  = 0;
      end else if (burst_go && burst_n != 0) begin
        m_bvalid = 1; m_bstart = cyc; m_bn = burst_n; m_bbusy = 1;
      end else if (ev[1]) begin
        m_bvalid = 1; m_bstart = cyc; m_bn = 1; m_bbusy = 0;
      end
    end
    now_step   = m_bvalid && ((cyc - m_bstart) <= last_off());
    exp_halt   = !m_running;
    exp_en_l   = !(now_step && ((cyc - m_bstart) % (GAP + 1) == 0));
    exp_busy   = now_step && m_bbusy;
    exp_bp_hit = m_bp_hit;
  endtask

  always @(posedge clk) if (rst_n) model_edge();

  // ---------------- scoreboard: every cycle out of reset ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("halt",   halt,   exp_halt);
      check("en_l",   en_l,   exp_en_l);
      check("busy",   busy,   exp_busy);
      check("bp_hit", bp_hit, exp_bp_hit);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press_run();
    run_btn = 1'b1;
    repeat (6) @(negedge clk);
    run_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int lows, first, t, run_hold, step_hold;
    bit halt_all, pressed;
    logic [7:0] got_en, got_busy;

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_halt",   halt,   1'b1);
    check("reset_en_l",   en_l,   1'b1);
    check("reset_busy",   busy,   1'b0);
    check("reset_bp_hit", bp_hit, 1'b0);
    repeat (2) @(negedge clk);

    // Single step: held 10 cycles, one pulse 7 cycles after the press.
    step_btn = 1'b1;
    lows = 0; first = 0; halt_all = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (!en_l) begin
        lows++;
        if (first == 0) first = i;
      end
      halt_all &= halt;
      if (i == 10) step_btn = 1'b0;
    end
    check("step_pulses",  lows,     1);
    check("step_latency", first,    7);
    check("step_halt",    halt_all, 1'b1);
    repeat (10) @(negedge clk);

    // Bouncing STEP: toggles every 2 cycles, never stable long enough.
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      step_btn = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      @(negedge clk);
      if (!en_l) lows++;
    end
    check("bounce_pulses", lows, 0);
    check("bounce_halt",   halt, 1'b1);

    // Burst of 3 with GAP=2.
    burst_n = 8'd3; burst_go = 1'b1;
    @(negedge clk);
    burst_go = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got_en[i]   = en_l;
      got_busy[i] = busy;
      @(negedge clk);
    end
    check("burst3_en_l", got_en,   8'b1011_0110);
    check("burst3_busy", got_busy, 8'b0111_1111);
    repeat (3) @(negedge clk);

    // Run then breakpoint.
    bp_en = 1'b1; bp_addr = 8'h2A; pc = 8'h00;
    press_run();
    check("run_halt_low", halt, 1'b0);
    pc = 8'h2A;
    @(negedge clk);
    check("bp_halt", halt,   1'b1);
    check("bp_flag", bp_hit, 1'b1);
    pc = 8'h00; bp_en = 1'b0;
    press_run();
    check("rerun_halt",   halt,   1'b0);
    check("rerun_bp_clr", bp_hit, 1'b0);
    press_run();
    check("stop_halt", halt, 1'b1);

    // Long burst aborted by RUN after the 5th pulse; two more pulses land
    // inside the 7-cycle press latency, then nothing.
    burst_n = 8'd200; burst_go = 1'b1;
    @(negedge clk);
    burst_go = 1'b0;
    lows = 0; pressed = 0; t = 0;
    for (int i = 0; i < 70; i++) begin
      if (!en_l) lows++;
      if (lows == 5 && !pressed) begin
        run_btn = 1'b1;
        pressed = 1;
      end
      if (pressed) begin
        t++;
        if (t == 7) run_btn = 1'b0;
      end
      @(negedge clk);
    end
    check("abort_pulses", lows, 7);
    check("abort_busy",   busy, 1'b0);
    check("abort_halt",   halt, 1'b1);

    // Asynchronous reset in the middle of a burst, on an EN_L-low cycle.
    burst_n = 8'd10; burst_go = 1'b1;
    @(negedge clk);
    burst_go = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_burst_en_l", en_l, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_en_l", en_l, 1'b1);
    check("async_halt", halt, 1'b1);
    check("async_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!en_l) lows++;
    end
    check("post_reset_pulses", lows, 0);

    // Randomized traffic; the scoreboard checks every cycle.
    bp_addr = 8'h05; run_hold = 0; step_hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (run_hold == 0) begin
        run_btn  = ($urandom_range(0, 4) == 0);
        run_hold = $urandom_range(1, 12);
      end else run_hold--;
      if (step_hold == 0) begin
        step_btn  = $urandom_range(0, 1);
        step_hold = $urandom_range(1, 10);
      end else step_hold--;
      burst_go = ($urandom_range(0, 19) == 0);
      burst_n  = 8'($urandom_range(0, 5));
      pc       = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) bp_en = $urandom_range(0, 1);
      @(negedge clk);
    end
    burst_go = 1'b0; run_btn = 1'b0; step_btn = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
